// File: rtl/pwm_peripheral_if.sv
// Register-side bundle for pwm_peripheral: configuration registers in, drive outputs back.
// master = register block / bench side, slave = PWM peripheral side.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-output PWM driver: one free-running 8-bit PWM routed per output as off / static high / PWM.
// Optional PWM_SHADOW_DUTY_EN: duty is sampled only at period wrap instead of used live.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q;
    logic        tick;
    logic        wrap;
    logic        pwm_sig;
    logic [7:0]  duty;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    always_comb begin
        tick      = (pre_cnt_q == PRE_MAX);
        wrap      = tick && (pwm_cnt_q == 8'hFF);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // 0xFF forced fully on so full duty has no one-step low gap
        pwm_sig   = (duty == 8'hFF) || (pwm_cnt_q < duty);
        out_d     = en_out & (~en_pwm | {16{pwm_sig}});
    end

`ifdef PWM_SHADOW_DUTY_EN
    logic [7:0] duty_q, duty_d;

    assign duty_d = wrap ? bus.pwm_duty_cycle : duty_q;
    assign duty   = duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end
`else
    assign duty = bus.pwm_duty_cycle;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule
